ram_readout_seq: RTL

//  Reader side of the acquisition sample RAMs: after capture completes (data_ready), walks each enabled

---
 rtl/ram_readout_seq_pkg.sv | 21 ++
 rtl/ram_readout_seq_if.sv | 10 +
 rtl/ram_readout_seq_addr.sv | 67 ++++++
 rtl/ram_readout_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_readout_seq_pkg.sv
// Shared definitions for the sample-RAM readout sequencer: FSM state
// encoding and the checksum accumulate helper.
// Optional feature macro: READOUT_CHECKSUM_EN (see ram_readout_seq.sv).
package ram_readout_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_WT    = 3'd2,
      S_SEND  = 3'd3,
      S_NXTCH = 3'd4,
      S_CSUM  = 3'd5,
      S_FIN   = 3'd6
   } state_e;

   // 8-bit wrapping sum used for the per-channel trailer byte
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/ram_readout_seq_if.sv
// Byte stream toward the host link transmitter: valid/ready handshake,
// data held stable while valid is high and ready is low.
interface ram_readout_seq_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ram_readout_seq_addr.sv
// Read address generator: latches the oldest-sample address and sample
// count on load, walks a wrapping RAM_W address with a sample counter,
// and flags the step that completes a channel.
module ram_readout_seq_addr #(
   parameter int RAM_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [RAM_W-1:0] trig_addr_i,
   input  logic [RAM_W-1:0] pre_samples_i,
   input  logic [RAM_W-1:0] nsmp_i,
   input  logic             restart_i,
   input  logic             step_i,
   output logic [RAM_W-1:0] addr_o,
   output logic             last_o,
   output logic             nsmp_zero_o
);

   logic [RAM_W-1:0] start_q, start_d;
   logic [RAM_W-1:0] nsmp_q, nsmp_d;
   logic [RAM_W-1:0] addr_q, addr_d;
   logic [RAM_W-1:0] cnt_q, cnt_d;
   logic [RAM_W-1:0] cnt_inc;

   assign cnt_inc = cnt_q + 1'b1;

   // Load / rewind / advance; RAM_W-bit arithmetic gives the circular wrap
   always_comb begin
      start_d = start_q;
      nsmp_d  = nsmp_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         start_d = trig_addr_i - pre_samples_i;
         nsmp_d  = nsmp_i;
         addr_d  = trig_addr_i - pre_samples_i;
         cnt_d   = '0;
      end else if (restart_i) begin
         addr_d = start_q;
         cnt_d  = '0;
      end else if (step_i) begin
         addr_d = addr_q + 1'b1;
         cnt_d  = cnt_inc;
      end
   end

   // Address/count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         start_q <= '0;
         nsmp_q  <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         start_q <= start_d;
         nsmp_q  <= nsmp_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign addr_o      = addr_q;
   assign last_o      = (cnt_inc == nsmp_q);
   assign nsmp_zero_o = (nsmp_q == '0);

endmodule

// File: rtl/ram_readout_seq.sv
// Sample RAM readout sequencer: after capture, streams each enabled
// channel's circular buffer (oldest pre-trigger sample first, nsmp bytes)
// onto the TX byte interface, channels in ascending index order.
// Optional: define READOUT_CHECKSUM_EN to append an 8-bit wrapping sum
// byte after each channel's data.
module ram_readout_seq
   import ram_readout_seq_pkg::*;
#(
   parameter int RAM_W = 10,
   parameter int NCH   = 4,
   parameter int CH_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              data_ready,
   input  logic [RAM_W-1:0]  trig_addr,
   input  logic [RAM_W-1:0]  pre_samples,
   input  logic [RAM_W-1:0]  nsmp,
   input  logic [NCH-1:0]    chan_mask,
   output logic              rden,
   output logic [RAM_W-1:0]  rdaddress,
   output logic [CH_W-1:0]   rdchan,
   input  logic [7:0]        rddata,
   ram_readout_seq_if.master tx,
   output logic              busy,
   output logic              done
);

   state_e          state_q, state_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic [NCH-1:0]  mask_q, mask_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic            rden_q, rden_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
`ifdef READOUT_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
   logic            csum_sent_q, csum_sent_d;
`endif

   logic             load, restart, step;
   logic [RAM_W-1:0] addr;
   logic             last, nsmp_zero;
   logic [CH_W:0]    pick_in, pick_nx;

   // Lowest set bit of a mask; MSB of the result flags that one was found
   function automatic logic [CH_W:0] pick_low(input logic [NCH-1:0] m);
      logic [CH_W:0] r;
      r = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (m[i]) r = {1'b1, CH_W'(i)};
      end
      return r;
   endfunction

   assign pick_in = pick_low(chan_mask);
   assign pick_nx = pick_low(mask_q);

   ram_readout_seq_addr #(.RAM_W(RAM_W)) u_addr (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load),
      .trig_addr_i  (trig_addr),
      .pre_samples_i(pre_samples),
      .nsmp_i       (nsmp),
      .restart_i    (restart),
      .step_i       (step),
      .addr_o       (addr),
      .last_o       (last),
      .nsmp_zero_o  (nsmp_zero)
   );

   // Next-state and registered-output logic; mask_q holds channels still to send
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      mask_d     = mask_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      rden_d     = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      load       = 1'b0;
      restart    = 1'b0;
      step       = 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum_d      = csum_q;
      csum_sent_d = csum_sent_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && data_ready) begin
               load   = 1'b1;
               busy_d = 1'b1;
               mask_d = chan_mask;
               if (pick_in[CH_W]) begin
                  ch_d = pick_in[CH_W-1:0];
                  mask_d[pick_in[CH_W-1:0]] = 1'b0;
               end
`ifdef READOUT_CHECKSUM_EN
               csum_d      = '0;
               csum_sent_d = 1'b0;
               if (!pick_in[CH_W]) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else if (nsmp == '0) begin
                  state_d = S_NXTCH;
               end else begin
                  state_d = S_RD;
                  rden_d  = 1'b1;
               end
`else
               if (!pick_in[CH_W] || nsmp == '0) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_RD;
                  rden_d  = 1'b1;
               end
`endif
            end
         end
         S_RD: begin
            state_d = S_WT;
         end
         S_WT: begin
            tx_data_d  = rddata;
            tx_valid_d = 1'b1;
`ifdef READOUT_CHECKSUM_EN
            csum_d = csum_add(csum_q, rddata);
`endif
            state_d = S_SEND;
         end
         S_SEND: begin
            if (tx.tx_ready) begin
               tx_valid_d = 1'b0;
               step       = 1'b1;
               if (last) begin
                  state_d = S_NXTCH;
`ifdef READOUT_CHECKSUM_EN
                  csum_sent_d = 1'b0;
`endif
               end else begin
                  state_d = S_RD;
                  rden_d  = 1'b1;
               end
            end
         end
         S_NXTCH: begin
`ifdef READOUT_CHECKSUM_EN
            if (!csum_sent_q) begin
               tx_data_d  = csum_q;
               tx_valid_d = 1'b1;
               state_d    = S_CSUM;
            end else if (pick_nx[CH_W]) begin
               ch_d                      = pick_nx[CH_W-1:0];
               mask_d[pick_nx[CH_W-1:0]] = 1'b0;
               restart                   = 1'b1;
               csum_d                    = '0;
               csum_sent_d               = 1'b0;
               if (nsmp_zero) begin
                  state_d = S_NXTCH;
               end else begin
                  state_d = S_RD;
                  rden_d  = 1'b1;
               end
            end else begin
               state_d = S_FIN;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
`else
            if (pick_nx[CH_W] && !nsmp_zero) begin
               ch_d                      = pick_nx[CH_W-1:0];
               mask_d[pick_nx[CH_W-1:0]] = 1'b0;
               restart                   = 1'b1;
               state_d                   = S_RD;
               rden_d                    = 1'b1;
            end else begin
               state_d = S_FIN;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
`endif
         end
`ifdef READOUT_CHECKSUM_EN
         S_CSUM: begin
            if (tx.tx_ready) begin
               tx_valid_d  = 1'b0;
               csum_sent_d = 1'b1;
               state_d     = S_NXTCH;
            end
         end
`endif
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs; reset abandons any readout in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         mask_q      <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         rden_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
         csum_q      <= '0;
         csum_sent_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         mask_q      <= mask_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         rden_q      <= rden_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef READOUT_CHECKSUM_EN
         csum_q      <= csum_d;
         csum_sent_q <= csum_sent_d;
`endif
      end
   end

   assign rden        = rden_q;
   assign rdaddress   = addr;
   assign rdchan      = ch_q;
   assign tx.tx_data  = tx_data_q;
   assign tx.tx_valid = tx_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
